axi4_lite_default_slave: RTL and testbench
==========================================

AXI4_LITE_DEFAULT_SLAVE -- requirements
Module: axi4_lite_default_slave

Interface
- REQ-001 Parameter I, default 0, ID width in bits; 0 = no ID ports driven; legal 0..8.
- REQ-002 Parameter DW, default 32, data width; legal 32 or 64.
- REQ-003 Parameter D, default 'hbaadc0de, read data value, zero-extended to DW.
- REQ-004 Parameter RESP, default 2'b11 (DECERR), value driven on bresp and rresp.
- REQ-005 Parameter DEPTH, default 4, outstanding transactions per channel; power of two, 1..8.
- REQ-006 aclk  in  1  clock; all logic on rising edge.
- REQ-007 aresetn  in  1  reset, synchronous, active-low.
- REQ-008 awvalid/awready  in/out  1  write address handshake; awid  in  I.
- REQ-009 wvalid/wready  in/out  1  write data handshake; wdata and wstrb are ignored.
- REQ-010 bvalid/bready  out/in  1  write response handshake; bid  out  I; bresp  out  2.
- REQ-011 arvalid/arready  in/out  1  read address handshake; arid  in  I.
- REQ-012 rvalid/rready  out/in  1  read response handshake; rid  out  I; rdata  out  DW; rresp  out  2.
- REQ-013 wr_cnt, rd_cnt  out  16  accepted write/read transaction counts; present only when the macro in REQ-029 is defined.

Function
- REQ-014 awready = (AW queue count < DEPTH), independent of wvalid; an AW beat accepted on awvalid&awready pushes awid.
- REQ-015 wready = (W token count < DEPTH), independent of awvalid; a W beat accepted on wvalid&wready increments the W token count.
- REQ-016 AW and W for one transaction are accepted in either order or in the same cycle.
- REQ-017 bvalid = (AW queue non-empty) & (W token count > 0); bid = head of AW queue; bresp = RESP.
- REQ-018 On bvalid&bready: pop the AW queue and decrement the W token count in the same cycle.
- REQ-019 Minimum write latency: bvalid asserts the cycle after the later of the AW and W handshakes.
- REQ-020 arready = (AR queue count < DEPTH); an accepted AR pushes arid.
- REQ-021 rvalid = AR queue non-empty; rid = head; rdata = D; rresp = RESP; pop on rvalid&rready.
- REQ-022 Minimum read latency: rvalid asserts the cycle after the AR handshake.
- REQ-023 Simultaneous push and pop on a full queue is permitted: ready is computed from the pre-pop count, so a full queue does not accept a push in the same cycle it pops.
- REQ-024 Simultaneous push and pop on any non-full queue leaves the count unchanged.
- REQ-025 Response ordering is FIFO per channel; queue pointers wrap modulo DEPTH.
- REQ-026 bvalid and rvalid, once asserted, hold with stable bid/rid until the response handshake completes.
- REQ-027 No combinational path from any input valid to the same channel's ready.

Reset
- REQ-028 While aresetn = 0 at a clock edge: all queues are emptied, all counts are cleared, and awready = wready = arready = 1 from the next cycle, bvalid = rvalid = 0, and wr_cnt = rd_cnt = 0; reset mid-transaction discards all pending responses with no response issued.

Configuration
- REQ-029 Macro AXI4_LITE_DEFAULT_SLAVE_CNT_EN defined: wr_cnt increments on each B handshake and rd_cnt on each R handshake; both saturate at 16'hffff.
- REQ-030 Macro AXI4_LITE_DEFAULT_SLAVE_CNT_EN undefined: the counters and ports are absent, and the block's functional behaviour is otherwise identical.

Verification
- REQ-031 Write with AW at cycle 0 and W at cycle 3, awid=5 -> bvalid at cycle 4, bid=5, bresp=2'b11.
- REQ-032 DEPTH=4, four ARs with arid 1..4 and rready=0 -> arready=0 after the 4th; then rready=1 -> rid 1,2,3,4 in order with rdata='hbaadc0de.
- REQ-033 Full AR queue with arvalid=1 and rready=1 in the same cycle -> one pop, no push that cycle; push accepted the next cycle.
- REQ-034 Three W beats before any AW -> no bvalid; each subsequent AW yields one B, three Bs total.
- REQ-035 aresetn low for 1 cycle with 2 reads pending -> rvalid=0 and arready=1 after reset; no stale rid is ever emitted.
- REQ-036 With CNT_EN defined, 70000 reads -> rd_cnt=16'hffff and holds.

Source files
------------

// File: rtl/axi4_lite_default_slave.sv
// axi4_lite_default_slave
//   Default (catch-all) AXI4-Lite slave. Every write and read is accepted and
//   answered with response code RESP; reads return the constant D. Each
//   channel keeps up to DEPTH outstanding transactions, answered in FIFO order.
//
// Parameters
//   I     ID width (0 = IDs not used, bid/rid driven to zero)
//   DW    data width, 32 or 64
//   D     read data value, zero-extended to DW
//   RESP  response code driven on bresp/rresp
//   DEPTH outstanding transactions per channel, power of two, 1..8
//
// Ports
//   aclk, aresetn                 clock, synchronous active-low reset
//   i_awvalid/o_awready, i_awid   write address handshake
//   i_wvalid/o_wready, i_wdata,
//   i_wstrb                       write data handshake (data/strobes ignored)
//   o_bvalid/i_bready, o_bid,
//   o_bresp                       write response
//   i_arvalid/o_arready, i_arid   read address handshake
//   o_rvalid/i_rready, o_rid,
//   o_rdata, o_rresp              read response
//   o_wr_cnt, o_rd_cnt            saturating B/R handshake counters, present
//                                 only when AXI4_LITE_DEFAULT_SLAVE_CNT_EN is
//                                 defined
//
// All ready outputs are derived from registered occupancy only, so there is
// no combinational path from a valid input to the same channel's ready.

// ID queue: DEPTH-entry FIFO of transaction IDs with registered occupancy.
//   i_push/i_push_id  enqueue (ignored when full)
//   i_pop             dequeue head (ignored when empty)
//   o_not_full        occupancy below DEPTH (pre-pop value)
//   o_not_empty       at least one entry present
//   o_head            oldest entry
module axi4_lite_default_slave_idq #(
  parameter int unsigned W     = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         i_push,
  input  logic [W-1:0] i_push_id,
  input  logic         i_pop,
  output logic         o_not_full,
  output logic         o_not_empty,
  output logic [W-1:0] o_head
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_not_full  = (r_cnt < CW'(DEPTH));
  assign o_not_empty = (r_cnt != '0);
  assign o_head      = r_mem[r_rp];
  assign w_push      = i_push & o_not_full;
  assign w_pop       = i_pop & o_not_empty;

  always_ff @(posedge aclk) begin
    if (w_push) r_mem[r_wp] <= i_push_id;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= f_inc(r_wp);
      if (w_pop)  r_rp <= f_inc(r_rp);
      if (w_push && !w_pop)      r_cnt <= r_cnt + CW'(1);
      else if (!w_push && w_pop) r_cnt <= r_cnt - CW'(1);
    end
  end
endmodule

module axi4_lite_default_slave #(
  parameter int unsigned I     = 0,
  parameter int unsigned DW    = 32,
  parameter logic [63:0] D     = 64'hbaadc0de,
  parameter logic [1:0]  RESP  = 2'b11,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned IW   = (I > 0) ? I : 1
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic            i_awvalid,
  output logic            o_awready,
  input  logic [IW-1:0]   i_awid,
  input  logic            i_wvalid,
  output logic            o_wready,
  input  logic [DW-1:0]   i_wdata,
  input  logic [DW/8-1:0] i_wstrb,
  output logic            o_bvalid,
  input  logic            i_bready,
  output logic [IW-1:0]   o_bid,
  output logic [1:0]      o_bresp,
  input  logic            i_arvalid,
  output logic            o_arready,
  input  logic [IW-1:0]   i_arid,
  output logic            o_rvalid,
  input  logic            i_rready,
  output logic [IW-1:0]   o_rid,
  output logic [DW-1:0]   o_rdata,
  output logic [1:0]      o_rresp
`ifdef AXI4_LITE_DEFAULT_SLAVE_CNT_EN
  ,
  output logic [15:0]     o_wr_cnt,
  output logic [15:0]     o_rd_cnt
`endif
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [IW-1:0] w_awid;
  logic [IW-1:0] w_arid;
  logic          w_aw_ne;
  logic          w_aw_acc;
  logic          w_w_acc;
  logic          w_b_hs;
  logic          w_ar_acc;
  logic          w_r_hs;
  logic [CW-1:0] r_wtok;
  logic          w_unused_wdata;

  // Write data content is irrelevant to a default slave.
  assign w_unused_wdata = ^{i_wdata, i_wstrb};

  // Without IDs the queues only track occupancy; stored IDs stay zero.
  assign w_awid = (I > 0) ? i_awid : '0;
  assign w_arid = (I > 0) ? i_arid : '0;

  assign w_aw_acc = i_awvalid & o_awready;
  assign w_w_acc  = i_wvalid & o_wready;
  assign w_b_hs   = o_bvalid & i_bready;
  assign w_ar_acc = i_arvalid & o_arready;
  assign w_r_hs   = o_rvalid & i_rready;

  axi4_lite_default_slave_idq #(
    .W     (IW),
    .DEPTH (DEPTH)
  ) u_awq (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .i_push      (i_awvalid),
    .i_push_id   (w_awid),
    .i_pop       (w_b_hs),
    .o_not_full  (o_awready),
    .o_not_empty (w_aw_ne),
    .o_head      (o_bid)
  );

  axi4_lite_default_slave_idq #(
    .W     (IW),
    .DEPTH (DEPTH)
  ) u_arq (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .i_push      (i_arvalid),
    .i_push_id   (w_arid),
    .i_pop       (w_r_hs),
    .o_not_full  (o_arready),
    .o_not_empty (o_rvalid),
    .o_head      (o_rid)
  );

  // W beats are counted as tokens independently of AW, so the two halves of
  // a write may arrive in either order; a B needs one of each.
  assign o_wready = (r_wtok < CW'(DEPTH));
  assign o_bvalid = w_aw_ne & (r_wtok != '0);
  assign o_bresp  = RESP;
  assign o_rdata  = D[DW-1:0];
  assign o_rresp  = RESP;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_wtok <= '0;
    end else if (w_w_acc && !w_b_hs) begin
      r_wtok <= r_wtok + CW'(1);
    end else if (!w_w_acc && w_b_hs) begin
      r_wtok <= r_wtok - CW'(1);
    end
  end

`ifdef AXI4_LITE_DEFAULT_SLAVE_CNT_EN
  logic [15:0] r_wr_cnt;
  logic [15:0] r_rd_cnt;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else begin
      if (w_b_hs && (r_wr_cnt != '1)) r_wr_cnt <= r_wr_cnt + 16'd1;
      if (w_r_hs && (r_rd_cnt != '1)) r_rd_cnt <= r_rd_cnt + 16'd1;
    end
  end

  assign o_wr_cnt = r_wr_cnt;
  assign o_rd_cnt = r_rd_cnt;
`else
  // Counters absent: handshakes only drive the response queues.
`endif
endmodule

// File: tb/tb_axi4_lite_default_slave.sv
module tb_axi4_lite_default_slave;
  localparam int unsigned DEPTH = 4;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        i_awvalid = 1'b0;
  logic        o_awready;
  logic [3:0]  i_awid = '0;
  logic        i_wvalid = 1'b0;
  logic        o_wready;
  logic [31:0] i_wdata = '0;
  logic [3:0]  i_wstrb = '0;
  logic        o_bvalid;
  logic        i_bready = 1'b0;
  logic [3:0]  o_bid;
  logic [1:0]  o_bresp;
  logic        i_arvalid = 1'b0;
  logic        o_arready;
  logic [3:0]  i_arid = '0;
  logic        o_rvalid;
  logic        i_rready = 1'b0;
  logic [3:0]  o_rid;
  logic [31:0] o_rdata;
  logic [1:0]  o_rresp;
`ifdef AXI4_LITE_DEFAULT_SLAVE_CNT_EN
  logic [15:0] o_wr_cnt;
  logic [15:0] o_rd_cnt;
`endif

  always #5 aclk = ~aclk;

  axi4_lite_default_slave #(
    .I     (4),
    .DW    (32),
    .D     (64'hbaadc0de),
    .RESP  (2'b11),
    .DEPTH (DEPTH)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .i_awvalid (i_awvalid),
    .o_awready (o_awready),
    .i_awid    (i_awid),
    .i_wvalid  (i_wvalid),
    .o_wready  (o_wready),
    .i_wdata   (i_wdata),
    .i_wstrb   (i_wstrb),
    .o_bvalid  (o_bvalid),
    .i_bready  (i_bready),
    .o_bid     (o_bid),
    .o_bresp   (o_bresp),
    .i_arvalid (i_arvalid),
    .o_arready (o_arready),
    .i_arid    (i_arid),
    .o_rvalid  (o_rvalid),
    .i_rready  (i_rready),
    .o_rid     (o_rid),
    .o_rdata   (o_rdata),
    .o_rresp   (o_rresp)
`ifdef AXI4_LITE_DEFAULT_SLAVE_CNT_EN
    ,
    .o_wr_cnt  (o_wr_cnt),
    .o_rd_cnt  (o_rd_cnt)
`endif
  );

  // Reference model: outstanding IDs per channel as queues, W beats as a count.
  logic [3:0] m_aw[$];
  logic [3:0] m_ar[$];
  int         m_wtok;
  longint     m_wr;
  longint     m_rd;

  int unsigned n_pass = 0;
  int unsigned n_chk  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] sat16(input longint v);
    return (v > 65535) ? 16'hffff : 16'(v);
  endfunction

  task automatic model_clear();
    m_aw.delete();
    m_ar.delete();
    m_wtok = 0;
    m_wr   = 0;
    m_rd   = 0;
  endtask

  task automatic do_reset();
    aresetn   = 1'b0;
    i_awvalid = 1'b0;
    i_wvalid  = 1'b0;
    i_arvalid = 1'b0;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    model_clear();
  endtask

  // One clock: drive inputs, check outputs mid-cycle against the model,
  // then advance the model by the handshakes the coming edge will perform.
  task automatic cycle(input logic aw, input logic [3:0] awid, input logic w,
                       input logic b, input logic ar, input logic [3:0] arid,
                       input logic r);
    bit e_awr;
    bit e_wr;
    bit e_bv;
    bit e_arr;
    bit e_rv;
    i_awvalid = aw;
    i_awid    = awid;
    i_wvalid  = w;
    i_wdata   = $urandom;
    i_wstrb   = 4'($urandom);
    i_bready  = b;
    i_arvalid = ar;
    i_arid    = arid;
    i_rready  = r;
    #3;
    e_awr = (m_aw.size() < DEPTH);
    e_wr  = (m_wtok < int'(DEPTH));
    e_bv  = (m_aw.size() != 0) && (m_wtok > 0);
    e_arr = (m_ar.size() < DEPTH);
    e_rv  = (m_ar.size() != 0);
    chk("awready", 64'(o_awready), 64'(e_awr));
    chk("wready",  64'(o_wready),  64'(e_wr));
    chk("bvalid",  64'(o_bvalid),  64'(e_bv));
    chk("arready", 64'(o_arready), 64'(e_arr));
    chk("rvalid",  64'(o_rvalid),  64'(e_rv));
    if (e_bv) begin
      chk("bid",   64'(o_bid),   64'(m_aw[0]));
      chk("bresp", 64'(o_bresp), 64'(2'b11));
    end
    if (e_rv) begin
      chk("rid",   64'(o_rid),   64'(m_ar[0]));
      chk("rdata", 64'(o_rdata), 64'h0000_0000_baad_c0de);
      chk("rresp", 64'(o_rresp), 64'(2'b11));
    end
`ifdef AXI4_LITE_DEFAULT_SLAVE_CNT_EN
    chk("wr_cnt", 64'(o_wr_cnt), 64'(sat16(m_wr)));
    chk("rd_cnt", 64'(o_rd_cnt), 64'(sat16(m_rd)));
`endif
    if (e_bv && b) begin
      void'(m_aw.pop_front());
      m_wtok = m_wtok - 1;
      m_wr   = m_wr + 1;
    end
    if (aw && e_awr) m_aw.push_back(awid);
    if (w && e_wr) m_wtok = m_wtok + 1;
    if (e_rv && r) begin
      void'(m_ar.pop_front());
      m_rd = m_rd + 1;
    end
    if (ar && e_arr) m_ar.push_back(arid);
    @(posedge aclk);
    #1;
  endtask

  task automatic idle(input int n, input logic b, input logic r);
    for (int k = 0; k < n; k++) cycle(1'b0, 4'd0, 1'b0, b, 1'b0, 4'd0, r);
  endtask

  initial begin
    model_clear();
    do_reset();
    do_reset();

    // Reset state.
    chk("rst_awready", 64'(o_awready), 64'd1);
    chk("rst_wready",  64'(o_wready),  64'd1);
    chk("rst_arready", 64'(o_arready), 64'd1);
    chk("rst_bvalid",  64'(o_bvalid),  64'd0);
    chk("rst_rvalid",  64'(o_rvalid),  64'd0);
    idle(1, 1'b0, 1'b0);

    // AW at cycle 0, W at cycle 3: B visible at cycle 4 with bid 5.
    cycle(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    idle(2, 1'b0, 1'b0);
    cycle(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    chk("b_latency", 64'(o_bvalid), 64'd1);
    chk("b_id5",     64'(o_bid),    64'd5);
    cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    cycle(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    idle(1, 1'b1, 1'b0);

    // Fill AR queue with ids 1..4, a 5th request must be held off.
    for (int k = 1; k <= 4; k++) cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'(k), 1'b0);
    chk("ar_full", 64'(o_arready), 64'd0);
    cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd9, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      chk("r_order", 64'(o_rid), 64'(k));
      cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    end
    idle(1, 1'b0, 1'b1);

    // Full queue: pop and attempted push in the same cycle, push next cycle.
    for (int k = 1; k <= 4; k++) cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'(k + 8), 1'b0);
    cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd7, 1'b1);
    chk("full_pop_arready", 64'(o_arready), 64'd1);
    cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd7, 1'b0);
    chk("full_push_next", 64'(o_arready), 64'd0);
    idle(6, 1'b0, 1'b1);

    // Three W beats before any AW, then one AW per B.
    for (int k = 0; k < 3; k++) cycle(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    chk("w_only_no_b", 64'(o_bvalid), 64'd0);
    for (int k = 1; k <= 3; k++) begin
      cycle(1'b1, 4'(k), 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
      chk("w_first_b", 64'(o_bvalid), 64'd1);
      cycle(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    end
    idle(2, 1'b1, 1'b0);

    // Reset with two reads pending discards them.
    cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0);
    cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd6, 1'b0);
    chk("pre_rst_rvalid", 64'(o_rvalid), 64'd1);
    do_reset();
    chk("post_rst_rvalid",  64'(o_rvalid),  64'd0);
    chk("post_rst_arready", 64'(o_arready), 64'd1);
    idle(4, 1'b1, 1'b1);

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      cycle(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), 4'($urandom),
            1'($urandom_range(0, 2) != 0));
    end
    idle(12, 1'b1, 1'b1);

`ifdef AXI4_LITE_DEFAULT_SLAVE_CNT_EN
    // Read counter saturation.
    for (int k = 0; k < 70000; k++) cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'(k), 1'b1);
    idle(4, 1'b1, 1'b1);
    chk("rd_cnt_sat", 64'(o_rd_cnt), 64'hffff);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
